mc_control: RTL and testbench
=============================

# mc_control

Main control FSM for the multicycle processor. Sequences every instruction through fetch, decode, execute, memory and writeback. Each cycle it drives the datapath mux selects, register and PC write enables, and the 3-bit `alu_op` into the shared 32-bit ALU. It sits directly upstream of the ALU, consumes the ALU `zero` flag for branches, and runs a req/ack handshake with instruction/data memory.

## Interface
- `W`, 32: datapath width; only used for `instr` width checks.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `instr`  in  32  instruction register contents.
- `zero`  in  1  ALU zero flag, same cycle.
- `mem_ack`  in  1  memory done; may be asserted in the same cycle as `mem_req`.
- `mem_req`  out  1  memory access request.
- `mem_we`  out  1  write qualifier for `mem_req`.
- `iord`  out  1  address select: 0 = PC, 1 = ALUOut.
- `ir_write`  out  1  instruction register load.
- `pc_en`  out  1  PC load.
- `pc_src`  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alu_src_a`  out  1  ALU A input: 0 = PC, 1 = reg A.
- `alu_src_b`  out  2  ALU B input: 00 = reg B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- `alu_op`  out  3  0 MOV, 1 NOT, 2 ADD, 3 SUB, 4 OR, 5 AND, 7 SLT; 6 is never driven.
- `reg_dst`  out  1  destination select: 0 = rt, 1 = rd.
- `mem_to_reg`  out  1  writeback data: 0 = ALUOut, 1 = MDR.
- `reg_write`  out  1  register file write.
- `illegal`  out  1  sticky illegal-instruction flag.
- `state`  out  4  current state, for debug.

## Operation
- Opcode decode, `instr[31:26]`:
  - 00 R-type; 08 ADDI; 23 LW; 2B SW; 04 BEQ; 02 J.
- R-type funct decode, `instr[5:0]`:
  - 20 ADD; 22 SUB; 24 AND; 25 OR; 2A SLT; 27 NOT; 21 MOV.
- Any other opcode or funct is illegal.
- FETCH:
  - `mem_req`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=ADD, `pc_src`=00.
  - On `mem_ack`: `ir_write`=1, `pc_en`=1, go to DECODE. Otherwise hold all signals.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, ADD (branch target into ALUOut). Branch by opcode:
  - LW/SW → MEMADR; R-type → REXEC; ADDI → IEXEC; BEQ → BRANCH; J → JUMP.
  - Illegal → TRAP or FETCH; see Configuration.
- MEMADR: `alu_src_a`=1, `alu_src_b`=10, ADD. LW → MEMRD, SW → MEMWR.
- MEMRD: `mem_req`=1, `iord`=1; on ack go to MEMWB.
- MEMWB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0; go to FETCH.
- MEMWR: `mem_req`=1, `mem_we`=1, `iord`=1; on ack go to FETCH.
- REXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_op` from the funct decode; go to RWB.
- RWB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0; go to FETCH.
- IEXEC: `alu_src_a`=1, `alu_src_b`=10, ADD; go to IWB.
- IWB: `reg_write`=1, `reg_dst`=0; go to FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, SUB, `pc_src`=01, `pc_en`=`zero`; go to FETCH.
- JUMP: `pc_src`=10, `pc_en`=1; go to FETCH.
- Output defaults: every output not listed for a state is 0, and `alu_op` defaults to MOV (0).

## Timing
- Outputs are Moore-decoded from `state`, except:
  - `ir_write` and the FETCH `pc_en`, which are qualified by `mem_ack`;
  - the BRANCH `pc_en`, which is qualified by `zero`.
- State advances on the rising `clk` edge in the ack cycle. A same-cycle ack gives zero wait states.
- Cycles per instruction at zero wait: R/ADDI 4, LW 5, SW 4, BEQ 3, J 3. Each memory wait cycle adds one.
- `mem_req` stays high until acked. It never drops without an ack, except on reset.
- `mem_ack` outside FETCH/MEMRD/MEMWR is ignored.
- Reset:
  - While `rst_n`=0, `state`=FETCH, `illegal`=0, and every output is forced to 0.
  - Reset mid-operation abandons the current instruction immediately; no partial `reg_write` or `pc_en`.
  - The first `mem_req` appears in the first cycle after `rst_n` rises.

## Configuration
- `MC_CONTROL_TRAP_EN` defined:
  - An illegal instruction in DECODE goes to TRAP.
  - TRAP asserts `illegal`=1, drives no requests or writes, and holds until reset.
- `MC_CONTROL_TRAP_EN` undefined:
  - An illegal instruction in DECODE goes to FETCH with no side effects, i.e. it executes as a NOP.
  - `illegal` is tied 0 and the TRAP state code is unreachable.

## Structure
- Package `mc_pkg`: state enum (4-bit, TRAP = 4'hC), opcode and funct constants, ALUOp constants matching the ALU encoding, and `alu_src_b`/`pc_src` encodings.
- Sub-module `mc_alu_decode`: combinational funct → `alu_op` plus a `funct_illegal` flag, used in DECODE and REXEC.
- Top level holds the state register and the output decode.

## Test plan
- Reset, then ADD R-type (`instr`=0x00430820) with ack in the same cycle as req → states FETCH, DECODE, REXEC, RWB; `alu_op`=2 in REXEC; `reg_write`=1, `reg_dst`=1 in RWB; back in FETCH on cycle 5.
- LW (0x8C220004) with ack delayed 2 cycles in MEMRD → `mem_req`,`iord` held 3 cycles; MEMWB has `mem_to_reg`=1; total 7 cycles.
- BEQ (0x10220003): with `zero`=1 → `pc_en`=1, `pc_src`=01 in BRANCH; repeat with `zero`=0 → `pc_en`=0.
- Opcode 0x3F:
  - With `MC_CONTROL_TRAP_EN` → `state`=TRAP, `illegal`=1, no `mem_req` for 20 cycles.
  - Without it → FETCH next, no `reg_write`.
- Drop `rst_n` during MEMWR while waiting for ack → `mem_req`,`mem_we` go to 0 asynchronously (same cycle); after release, FETCH with `iord`=0.
- SLT funct 2A and NOT funct 27 → `alu_op`=7 and 1 respectively in REXEC; `alu_op` never equals 6 in any state.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle control unit: state codes, opcode and
// funct constants, ALU operation encoding and datapath mux encodings.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'h0,
        S_DECODE = 4'h1,
        S_MEMADR = 4'h2,
        S_MEMRD  = 4'h3,
        S_MEMWB  = 4'h4,
        S_MEMWR  = 4'h5,
        S_REXEC  = 4'h6,
        S_RWB    = 4'h7,
        S_IEXEC  = 4'h8,
        S_IWB    = 4'h9,
        S_BRANCH = 4'hA,
        S_JUMP   = 4'hB,
        S_TRAP   = 4'hC
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_NOT = 6'h27;
    localparam logic [5:0] FN_MOV = 6'h21;

    localparam logic [2:0] ALU_MOV = 3'd0;
    localparam logic [2:0] ALU_NOT = 3'd1;
    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_SUB = 3'd3;
    localparam logic [2:0] ALU_OR  = 3'd4;
    localparam logic [2:0] ALU_AND = 3'd5;
    localparam logic [2:0] ALU_SLT = 3'd7;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // True for every opcode the decoder knows how to sequence.
    function automatic logic opcode_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW) ||
               (op == OP_SW) || (op == OP_BEQ) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_control_alu_decode.sv
// R-type funct field to ALU operation decode, with an illegal-funct flag.
module mc_alu_decode
    import mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       funct_illegal
);

    // Map funct to the shared ALU encoding; unknown functs fall back to MOV.
    always_comb begin
        alu_op        = ALU_MOV;
        funct_illegal = 1'b0;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            FN_NOT:  alu_op = ALU_NOT;
            FN_MOV:  alu_op = ALU_MOV;
            default: funct_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Main control FSM of the multicycle processor.
// Optional feature macro MC_CONTROL_TRAP_EN: illegal instructions park the FSM
// in TRAP with a sticky illegal flag; otherwise they execute as a NOP.
module mc_control
    import mc_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] instr,
    input  logic         zero,
    input  logic         mem_ack,
    output logic         mem_req,
    output logic         mem_we,
    output logic         iord,
    output logic         ir_write,
    output logic         pc_en,
    output logic [1:0]   pc_src,
    output logic         alu_src_a,
    output logic [1:0]   alu_src_b,
    output logic [2:0]   alu_op,
    output logic         reg_dst,
    output logic         mem_to_reg,
    output logic         reg_write,
    output logic         illegal,
    output logic [3:0]   state
);

    state_t     st;
    logic [5:0] opcode;
    logic [2:0] funct_op;
    logic       funct_illegal;
    logic       instr_illegal;
    logic       unused_instr;

    assign opcode       = instr[31:26];
    assign unused_instr = ^instr[25:6];

    mc_alu_decode u_alu_decode (
        .funct         (instr[5:0]),
        .alu_op        (funct_op),
        .funct_illegal (funct_illegal)
    );

    assign instr_illegal = !opcode_legal(opcode) ||
                           ((opcode == OP_RTYPE) && funct_illegal);

`ifdef MC_CONTROL_TRAP_EN
    localparam state_t ILLEGAL_NEXT = S_TRAP;
`else
    localparam state_t ILLEGAL_NEXT = S_FETCH;
`endif

    // State register: sequence each instruction; memory states wait for ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= S_FETCH;
        end else begin
            case (st)
                S_FETCH:  if (mem_ack) st <= S_DECODE;
                S_DECODE: begin
                    if (instr_illegal)              st <= ILLEGAL_NEXT;
                    else if (opcode == OP_LW ||
                             opcode == OP_SW)       st <= S_MEMADR;
                    else if (opcode == OP_RTYPE)    st <= S_REXEC;
                    else if (opcode == OP_ADDI)     st <= S_IEXEC;
                    else if (opcode == OP_BEQ)      st <= S_BRANCH;
                    else                            st <= S_JUMP;
                end
                S_MEMADR: st <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  if (mem_ack) st <= S_MEMWB;
                S_MEMWR:  if (mem_ack) st <= S_FETCH;
                S_REXEC:  st <= S_RWB;
                S_IEXEC:  st <= S_IWB;
`ifdef MC_CONTROL_TRAP_EN
                S_TRAP:   st <= S_TRAP;
`endif
                default:  st <= S_FETCH;
            endcase
        end
    end

    // Output decode from state; everything is held at zero while rst_n is low
    // so a reset mid-access drops mem_req/writes without waiting for a clock.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_en      = 1'b0;
        pc_src     = PCSRC_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REGB;
        alu_op     = ALU_MOV;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        if (rst_n) begin
            case (st)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    alu_op    = ALU_ADD;
                    ir_write  = mem_ack;
                    pc_en     = mem_ack;
                end
                S_DECODE: begin
                    alu_src_b = SRCB_IMMSH;
                    alu_op    = ALU_ADD;
                end
                S_MEMADR, S_IEXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALU_ADD;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEMWR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    iord    = 1'b1;
                end
                S_REXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = funct_op;
                end
                S_RWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_IWB:   reg_write = 1'b1;
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_SUB;
                    pc_src    = PCSRC_ALUOUT;
                    pc_en     = zero;
                end
                S_JUMP: begin
                    pc_src = PCSRC_JUMP;
                    pc_en  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state = rst_n ? st : S_FETCH;

`ifdef MC_CONTROL_TRAP_EN
    assign illegal = rst_n && (st == S_TRAP);
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_mc_control.sv
// Directed testbench for mc_control. Outputs are packed into one vector and
// compared against hand-written per-state expectations each cycle.
module tb_mc_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ack;
    logic        mem_req, mem_we, iord, ir_write, pc_en;
    logic [1:0]  pc_src;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_op;
    logic        reg_dst, mem_to_reg, reg_write, illegal;
    logic [3:0]  state;
    logic [20:0] outs;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mc_control #(.W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .zero       (zero),
        .mem_ack    (mem_ack),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc_en      (pc_en),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .illegal    (illegal),
        .state      (state)
    );

    assign outs = {state, mem_req, mem_we, iord, ir_write, pc_en, pc_src,
                   alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg,
                   reg_write, illegal};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [20:0] mk(
        input logic [3:0] st, input logic req, input logic we,
        input logic io, input logic irw, input logic pce,
        input logic [1:0] pcs, input logic asa, input logic [1:0] asb,
        input logic [2:0] aop, input logic rd, input logic m2r,
        input logic rw, input logic ill);
        return {st, req, we, io, irw, pce, pcs, asa, asb, aop, rd, m2r, rw, ill};
    endfunction

    function automatic logic [20:0] x_fetch(input logic ack);
        return mk(4'h0, 1, 0, 0, ack, ack, 2'b00, 0, 2'b01, 3'd2, 0, 0, 0, 0);
    endfunction
    function automatic logic [20:0] x_decode();
        return mk(4'h1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 3'd2, 0, 0, 0, 0);
    endfunction
    function automatic logic [20:0] x_memadr();
        return mk(4'h2, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'd2, 0, 0, 0, 0);
    endfunction
    function automatic logic [20:0] x_memrd();
        return mk(4'h3, 1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 3'd0, 0, 0, 0, 0);
    endfunction
    function automatic logic [20:0] x_memwb();
        return mk(4'h4, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'd0, 0, 1, 1, 0);
    endfunction
    function automatic logic [20:0] x_memwr();
        return mk(4'h5, 1, 1, 1, 0, 0, 2'b00, 0, 2'b00, 3'd0, 0, 0, 0, 0);
    endfunction
    function automatic logic [20:0] x_rexec(input logic [2:0] aop);
        return mk(4'h6, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, aop, 0, 0, 0, 0);
    endfunction
    function automatic logic [20:0] x_rwb();
        return mk(4'h7, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'd0, 1, 0, 1, 0);
    endfunction
    function automatic logic [20:0] x_iexec();
        return mk(4'h8, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'd2, 0, 0, 0, 0);
    endfunction
    function automatic logic [20:0] x_iwb();
        return mk(4'h9, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'd0, 0, 0, 1, 0);
    endfunction
    function automatic logic [20:0] x_branch(input logic z);
        return mk(4'hA, 0, 0, 0, 0, z, 2'b01, 1, 2'b00, 3'd3, 0, 0, 0, 0);
    endfunction
    function automatic logic [20:0] x_jump();
        return mk(4'hB, 0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 3'd0, 0, 0, 0, 0);
    endfunction

    // Called at a falling edge: apply inputs, check settled outputs, then wait
    // for the next falling edge (the rising edge in between advances the FSM).
    task automatic cyc(input string tag, input logic ack, input logic z,
                       input logic [20:0] exp);
        mem_ack = ack;
        zero    = z;
        #1;
        check(tag, {11'd0, outs}, {11'd0, exp});
        check("alu_op_not6", {31'd0, alu_op == 3'd6}, 32'd0);
        @(negedge clk);
    endtask

    logic [5:0] fn_tab [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h21};
    logic [2:0] op_tab [7] = '{3'd2, 3'd3, 3'd5, 3'd4, 3'd7, 3'd1, 3'd0};

    initial begin
        rst_n   = 1'b0;
        instr   = 32'h0;
        zero    = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        #1;
        check("reset_outs", {11'd0, outs}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc("first_fetch_wait", 0, 0, x_fetch(0));

        // ADD, zero wait states; ack in REXEC must be ignored
        instr = 32'h00430820;
        cyc("add_fetch", 1, 0, x_fetch(1));
        cyc("add_decode", 0, 0, x_decode());
        cyc("add_rexec", 1, 0, x_rexec(3'd2));
        cyc("add_rwb", 0, 0, x_rwb());
        cyc("add_c5_fetch", 0, 0, x_fetch(0));

        // LW with two memory wait cycles in MEMRD
        instr = 32'h8C220004;
        cyc("lw_fetch", 1, 0, x_fetch(1));
        cyc("lw_decode", 0, 0, x_decode());
        cyc("lw_memadr", 0, 0, x_memadr());
        cyc("lw_memrd_w1", 0, 0, x_memrd());
        cyc("lw_memrd_w2", 0, 0, x_memrd());
        cyc("lw_memrd_ack", 1, 0, x_memrd());
        cyc("lw_memwb", 0, 0, x_memwb());
        cyc("lw_back_fetch", 0, 0, x_fetch(0));

        // SW, reset asserted while waiting for the write ack
        instr = 32'hAC220004;
        cyc("sw_fetch", 1, 0, x_fetch(1));
        cyc("sw_decode", 0, 0, x_decode());
        cyc("sw_memadr", 0, 0, x_memadr());
        cyc("sw_memwr_wait", 0, 0, x_memwr());
        mem_ack = 1'b0;
        #1;
        check("sw_memwr_pre_rst", {11'd0, outs}, {11'd0, x_memwr()});
        rst_n = 1'b0;
        #1;
        check("rst_async_outs", {11'd0, outs}, 32'd0);
        @(negedge clk);
        #1;
        check("rst_held_outs", {11'd0, outs}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc("rst_release_fetch", 0, 0, x_fetch(0));

        // BEQ taken then not taken
        instr = 32'h10220003;
        cyc("beq1_fetch", 1, 0, x_fetch(1));
        cyc("beq1_decode", 0, 0, x_decode());
        cyc("beq_taken", 0, 1, x_branch(1));
        cyc("beq2_fetch", 1, 0, x_fetch(1));
        cyc("beq2_decode", 0, 0, x_decode());
        cyc("beq_not_taken", 0, 0, x_branch(0));

        // J
        instr = 32'h08000010;
        cyc("j_fetch", 1, 0, x_fetch(1));
        cyc("j_decode", 0, 0, x_decode());
        cyc("j_jump", 0, 0, x_jump());

        // ADDI
        instr = 32'h20220005;
        cyc("addi_fetch", 1, 0, x_fetch(1));
        cyc("addi_decode", 0, 0, x_decode());
        cyc("addi_iexec", 0, 0, x_iexec());
        cyc("addi_iwb", 0, 0, x_iwb());

        // every R-type funct
        for (int i = 0; i < 7; i++) begin
            instr = {26'h0010C20, fn_tab[i]};
            cyc("r_fetch", 1, 0, x_fetch(1));
            cyc("r_decode", 0, 0, x_decode());
            cyc($sformatf("r_rexec_fn%h", fn_tab[i]), 0, 0, x_rexec(op_tab[i]));
            cyc("r_rwb", 0, 0, x_rwb());
        end

        // illegal opcode 0x3F
        instr = 32'hFC000000;
        cyc("ill_fetch", 1, 0, x_fetch(1));
        cyc("ill_decode", 0, 0, x_decode());
`ifdef MC_CONTROL_TRAP_EN
        for (int i = 0; i < 20; i++)
            cyc("ill_trap", logic'(i % 2), 0,
                mk(4'hC, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'd0, 0, 0, 0, 1));
        rst_n = 1'b0;
        #1;
        check("trap_rst_clear", {11'd0, outs}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc("trap_exit_fetch", 0, 0, x_fetch(0));
`else
        cyc("ill_nop_fetch", 0, 0, x_fetch(0));
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
